terminal_uart_ctrl: RTL



---
 rtl/terminal_uart_ctrl.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/terminal_uart_ctrl.sv
// Memory-mapped 8N1 UART: CPU TX bytes queue in a FIFO and are serialised; RX deserialises into a one-byte buffer.
// Latency: a TX push in cycle N pops in N+1 and the start bit appears in N+2; RX flags update one cycle after the mid-stop sample.
// Backpressure: none on the bus; a push into a full FIFO is dropped and latched in the sticky tx_overflow bit.
module terminal_uart_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        tx_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0]      BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   COUNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   COUNT_MAX = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus decode
  logic push_req, flush, stat_wr, done_wr, rd_clear;
  logic unused_dw;
  assign push_req  = we && (addr == 32'd1);
  assign stat_wr   = we && (addr == 32'd2);
  assign flush     = stat_wr && data_write[0];
  assign done_wr   = we && (addr == 32'd4);
  assign rd_clear  = re && (addr == 32'd3);
  assign unused_dw = ^data_write[31:8];

  // TX FIFO storage and bookkeeping
  logic [7:0]         fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               fifo_empty, fifo_full, push_ok, pop, ovf_set;

  // TX FSM state
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == COUNT_MAX);
  // Flush beats a simultaneous push, and suppresses its overflow too.
  assign push_ok    = push_req && !fifo_full && !flush;
  assign ovf_set    = push_req && fifo_full && !flush;
  assign pop        = (tx_state_q == S_IDLE) && !fifo_empty;

  // FIFO write port; storage needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= data_write[7:0];
  end

  // FIFO pointers and occupancy; a pop coinciding with a flush still hands its byte to the TX FSM.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // TX next-state: one IDLE cycle between frames is where the next byte is popped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_shift_d = fifo_mem_q[rd_ptr_q];
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
    endcase
    // Line level follows the next state so the output flop is glitch-free yet cycle-aligned.
    case (tx_state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  // TX state registers; reset aborts any frame in flight and idles the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_busy = (tx_state_q != S_IDLE);

  // RX path state
  logic [1:0]    rx_sync_q;
  logic          rx_s;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_complete, fe_set;
  logic [7:0]    rx_buf_q, rx_buf_d;
  logic          rx_done_q, rx_done_d;
  logic          ovf_q, ovf_d, fe_q, fe_d, ovr_q, ovr_d;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], uart_rx};
  end
  assign rx_s = rx_sync_q[1];

  // RX next-state: half a bit into the start bit, then whole bits, so every sample lands mid-bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_complete = 1'b0;
    fe_set      = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // A line back high at mid-start was a glitch, not a frame.
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_state_d  = S_IDLE;
          rx_complete = rx_s;
          fe_set      = !rx_s;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Buffer, done flag and sticky status next-state: set events always beat clears.
  always_comb begin
    rx_buf_d = rx_complete ? rx_shift_q : rx_buf_q;
    if (rx_complete)   rx_done_d = 1'b1;
    else if (done_wr)  rx_done_d = data_write[0];
    else if (rd_clear) rx_done_d = 1'b0;
    else               rx_done_d = rx_done_q;
    ovf_d = ovf_set | (ovf_q & ~(stat_wr & data_write[3]));
    fe_d  = fe_set  | (fe_q  & ~(stat_wr & data_write[4]));
    ovr_d = (rx_complete & rx_done_q) | (ovr_q & ~(stat_wr & data_write[5]));
  end

  // RX and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_buf_q   <= 8'd0;
      rx_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rx_done_q  <= rx_done_d;
      ovf_q      <= ovf_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  // Combinational read mux; unmapped words read as zero.
  always_comb begin
    data_read = 32'd0;
    case (addr)
      32'd2: begin
        data_read[0]             = fifo_empty;
        data_read[1]             = fifo_full;
        data_read[2]             = tx_busy;
        data_read[3]             = ovf_q;
        data_read[4]             = fe_q;
        data_read[5]             = ovr_q;
        data_read[8+FIFO_AW:8]   = count_q;
      end
      32'd3:   data_read[7:0] = rx_buf_q;
      32'd4:   data_read[0]   = rx_done_q;
      default: data_read = 32'd0;
    endcase
  end

endmodule
